// File: rtl/si_requant_scheduler_pkg.sv
// Shared constants for the requantisation scheduler: tag width helper and
// the saturation limits of the 8-bit activation format.
package si_requant_scheduler_pkg;

  localparam int SI_N_OUT   = 8;
  localparam int MAX_OUT_SI = (1 <<< (SI_N_OUT - 1)) - 1;
  localparam int MIN_OUT_SI = -(1 <<< (SI_N_OUT - 1));

  // A single-requester build still needs a one-bit tag field.
  function automatic int calc_tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/SI_DOWNSCALER_QUANT.sv
// Combinational requantiser: acc * M0 / 2^(32+SHIFT) rounded half-up,
// plus OFFSET, saturated to a signed N_OUT-bit value.
module SI_DOWNSCALER_QUANT #(
  parameter int          N_IN    = 32,
  parameter int          N_OUT   = 8,
  parameter logic [31:0] M0_0Q32 = 32'd1932735283,
  parameter int          SHIFT   = 10,
  parameter int          OFFSET  = 22
) (
  input  logic signed [N_IN-1:0]  i_acc,
  output logic signed [N_OUT-1:0] o_q
);

  // Headroom for the full product plus the rounding addend.
  localparam int PW = N_IN + 34;
  localparam logic signed [PW-1:0] MAX_V = PW'((1 <<< (N_OUT - 1)) - 1);
  localparam logic signed [PW-1:0] MIN_V = -MAX_V - 1;

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] rnd;
    rnd = PW'(1) <<< (31 + SHIFT);
    return (p + rnd) >>> (32 + SHIFT);
  endfunction

  function automatic logic signed [N_OUT-1:0] sat_out(input logic signed [PW-1:0] v);
    if (v > MAX_V) return MAX_V[N_OUT-1:0];
    if (v < MIN_V) return MIN_V[N_OUT-1:0];
    return v[N_OUT-1:0];
  endfunction

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_sum;

  assign w_prod = i_acc * $signed({1'b0, M0_0Q32});
  assign w_sum  = round_shift(w_prod) + PW'(OFFSET);
  assign o_q    = sat_out(w_sum);

endmodule

// File: rtl/si_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr,
// searching upward modulo N_REQ.
module si_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [TAG_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [TAG_W-1:0] o_winner
);

  always_comb begin
    logic             found;
    int               idx;
    logic [TAG_W-1:0] w_idx;
    o_grant  = '0;
    o_winner = '0;
    found    = 1'b0;
    idx      = 0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(i_ptr) + k) % N_REQ;
      w_idx = TAG_W'(idx);
      if (!found && i_valid[w_idx]) begin
        found          = 1'b1;
        o_winner       = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/si_requant_scheduler.sv
// Round-robin scheduler sharing one requantiser among N_REQ accumulator
// requesters, with a two-stage pipeline and tagged 8-bit results.
module si_requant_scheduler
  import si_requant_scheduler_pkg::*;
#(
  parameter int          N_REQ   = 4,
  parameter int          N_IN    = 32,
  parameter int          N_OUT   = 8,
  parameter logic [31:0] M0_0Q32 = 32'd1932735283,
  parameter int          SHIFT   = 10,
  parameter int          OFFSET  = 22,
  localparam int         TAG_W   = calc_tag_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*N_IN-1:0]  req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [N_OUT-1:0]       out_data,
  output logic [TAG_W-1:0]       out_tag,
  input  logic                   out_ready,
  output logic [15:0]            done_count
);

  logic [TAG_W-1:0]        r_ptr;
  logic                    r_vld_p1, r_vld_p2;
  logic signed [N_IN-1:0]  r_data_p1;
  logic signed [N_OUT-1:0] r_data_p2;
  logic [TAG_W-1:0]        r_tag_p1, r_tag_p2;
  logic [15:0]             r_done;

  logic [N_REQ-1:0]        w_grant;
  logic [TAG_W-1:0]        w_winner, w_ptr_next;
  logic signed [N_IN-1:0]  w_sel_data;
  logic signed [N_OUT-1:0] w_q;
  logic                    w_s2_free, w_s1_adv, w_s1_free, w_accept;

  si_rr_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W)) u_arb (
    .i_valid  (req_valid),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  SI_DOWNSCALER_QUANT #(
    .N_IN(N_IN), .N_OUT(N_OUT), .M0_0Q32(M0_0Q32), .SHIFT(SHIFT), .OFFSET(OFFSET)
  ) u_dq (
    .i_acc (r_data_p1),
    .o_q   (w_q)
  );

  assign w_s2_free  = !r_vld_p2 || out_ready;
  assign w_s1_adv   = r_vld_p1 && w_s2_free;
  assign w_s1_free  = !r_vld_p1 || w_s1_adv;
  // rst_n gates accept so no requester sees ready while reset is held.
  assign w_accept   = (|req_valid) && w_s1_free && !flush && rst_n;
  assign req_ready  = w_grant & {N_REQ{w_accept}};
  assign w_sel_data = req_data[int'(w_winner)*N_IN +: N_IN];
  assign w_ptr_next = (int'(w_winner) == N_REQ - 1) ? '0 : w_winner + 1'b1;

  assign out_valid  = r_vld_p2;
  assign out_data   = r_data_p2;
  assign out_tag    = r_tag_p2;
  assign done_count = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_tag_p1  <= '0;
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_tag_p2  <= '0;
      r_done    <= '0;
    end else begin
      // p1: arbitration winner captured
      if (flush)         r_vld_p1 <= 1'b0;
      else if (w_accept) r_vld_p1 <= 1'b1;
      else if (w_s1_adv) r_vld_p1 <= 1'b0;
      if (w_accept) begin
        r_data_p1 <= w_sel_data;
        r_tag_p1  <= w_winner;
        r_ptr     <= w_ptr_next;
      end
      // p2: requantised result held for the downstream handshake
      if (flush)          r_vld_p2 <= 1'b0;
      else if (w_s1_adv)  r_vld_p2 <= 1'b1;
      else if (out_ready) r_vld_p2 <= 1'b0;
      if (w_s1_adv && !flush) begin
        r_data_p2 <= w_q;
        r_tag_p2  <= r_tag_p1;
      end
      if (r_vld_p2 && out_ready) r_done <= r_done + 16'd1;
    end
  end

endmodule
